// File: rtl/debounce_sync_pkg.sv
// -----------------------------------------------------------------------------
// debounce_sync_pkg
//   Shared constants for the input-conditioning blocks.
//   Holds the 2-bit debounce FSM state encoding used by debounce_sync.
// -----------------------------------------------------------------------------
package debounce_sync_pkg;

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_WAIT_HI   = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_WAIT_LO   = 2'd3
   } state_t;

endpackage : debounce_sync_pkg

// File: rtl/debounce_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Plain flop shift chain that brings an asynchronous level into the CLK
//   domain. Reusable by any block that samples an external asynchronous input.
//
// Ports
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset; every flop loads INIT_LEVEL
//   D   : raw asynchronous input
//   Q   : synchronized level (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
   parameter int SYNC_STAGES = 2,
   parameter bit INIT_LEVEL  = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], D};
      end
   end

   assign Q = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Turns a raw asynchronous input into a clean, clock-synchronous level.
//   A sync_chain brings the input into the clock domain; a counter-based FSM
//   then accepts a new level only after DEBOUNCE_CYCLES consecutive
//   synchronized samples at that level. Feeds the rising-edge detector.
//
// Ports
//   CLK    : system clock, rising edge
//   RST    : asynchronous active-low reset
//   D_IN   : raw asynchronous input
//   EN     : debounce enable (the synchronizer runs regardless)
//   Q      : debounced level, registered
//   BUSY   : high while a candidate transition is being qualified
//   GLITCH : one-cycle pulse when a candidate transition is rejected
// -----------------------------------------------------------------------------
module debounce_sync
   import debounce_sync_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit INIT_LEVEL      = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic D_IN,
   input  logic EN,
   output logic Q,
   output logic BUSY,
   output logic GLITCH
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam state_t ST_RESET = INIT_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
      end
      if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
         $error("debounce_sync: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   logic             s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             busy_q, busy_d;
   logic             glitch_q, glitch_d;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
   ) u_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (D_IN),
      .Q   (s)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_RESET;
         cnt_q    <= '0;
         q_q      <= INIT_LEVEL;
         busy_q   <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         busy_q   <= busy_d;
         glitch_q <= glitch_d;
      end
   end

   // The sample that moves a STABLE state into WAIT already counts as the
   // first stable sample, so acceptance happens on the DEBOUNCE_CYCLES-th one.
   // The level check precedes the terminal-count check, so a sample that
   // returns to the old level on the terminal cycle is a reject, never an
   // acceptance; GLITCH and a Q change are therefore mutually exclusive.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      glitch_d = 1'b0;

      case (state_q)
         ST_STABLE_LO: begin
            cnt_d = '0;
            if (EN && s) begin
               state_d = ST_WAIT_HI;
               cnt_d   = CNT_ONE;
            end
         end

         ST_WAIT_HI: begin
            if (!EN) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
            end else if (!s) begin
               state_d  = ST_STABLE_LO;
               cnt_d    = '0;
               glitch_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
               q_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_STABLE_HI: begin
            cnt_d = '0;
            if (EN && !s) begin
               state_d = ST_WAIT_LO;
               cnt_d   = CNT_ONE;
            end
         end

         ST_WAIT_LO: begin
            if (!EN) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
            end else if (s) begin
               state_d  = ST_STABLE_HI;
               cnt_d    = '0;
               glitch_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
               q_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase

      // BUSY is registered from the next state so it lines up with state_q.
      busy_d = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
   end

   assign Q      = q_q;
   assign BUSY   = busy_q;
   assign GLITCH = glitch_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Directed scenarios plus randomized run-length stimulus for debounce_sync,
//   checked every cycle against a run-length reference model: the model keeps
//   the accepted level and the length of the current run of enabled samples
//   that differ from it, and flips the level once that run reaches
//   DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

   localparam int SYNC = 2;
   localparam int DEB  = 16;

   logic CLK = 1'b0;
   logic RST;
   logic D_IN;
   logic EN;
   logic Q;
   logic BUSY;
   logic GLITCH;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit sm[SYNC];
   bit q_m;
   bit glitch_m;
   int run_m;

   // observation bookkeeping
   int edge_n;
   int rise_edge;
   int rise_cnt;
   int glitch_cnt;
   bit q_prev;

   debounce_sync #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .INIT_LEVEL      (1'b0)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .D_IN   (D_IN),
      .EN     (EN),
      .Q      (Q),
      .BUSY   (BUSY),
      .GLITCH (GLITCH)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SYNC; i++) sm[i] = 1'b0;
      q_m      = 1'b0;
      glitch_m = 1'b0;
      run_m    = 0;
   endtask

   // One clock edge with the given inputs, then compare all outputs.
   task automatic step(input bit d, input bit en);
      bit s_old;
      D_IN = d;
      EN   = en;
      @(posedge CLK);
      s_old    = sm[SYNC-1];
      glitch_m = 1'b0;
      if (!en) begin
         run_m = 0;
      end else if (s_old == q_m) begin
         if (run_m > 0) glitch_m = 1'b1;
         run_m = 0;
      end else begin
         run_m++;
         if (run_m == DEB) begin
            q_m   = ~q_m;
            run_m = 0;
         end
      end
      for (int i = SYNC - 1; i > 0; i--) sm[i] = sm[i-1];
      sm[0] = d;
      edge_n++;
      #1;
      chk("Q", Q, q_m);
      chk("BUSY", BUSY, run_m > 0);
      chk("GLITCH", GLITCH, glitch_m);
      if (GLITCH === 1'b1) glitch_cnt++;
      if (Q === 1'b1 && !q_prev) begin
         rise_cnt++;
         rise_edge = edge_n;
      end
      q_prev = (Q === 1'b1);
   endtask

   task automatic steps(input bit d, input int n);
      for (int i = 0; i < n; i++) step(d, 1'b1);
   endtask

   // Assert reset mid-cycle, check it takes effect at once and holds for
   // five edges, then release just after an edge.
   task automatic async_reset(input string tag);
      D_IN = 1'b1;
      #3;
      RST = 1'b0;
      model_reset();
      #1;
      chk({tag, "_Q"}, Q, 1'b0);
      chk({tag, "_BUSY"}, BUSY, 1'b0);
      chk({tag, "_GLITCH"}, GLITCH, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         chk({tag, "_hold_Q"}, Q, 1'b0);
         chk({tag, "_hold_BUSY"}, BUSY, 1'b0);
         chk({tag, "_hold_GLITCH"}, GLITCH, 1'b0);
      end
      RST    = 1'b1;
      q_prev = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      int k;
      int g0;
      int r0;
      int len;
      bit lvl;
      bit en_r;

      RST  = 1'b0;
      D_IN = 1'b0;
      EN   = 1'b1;
      model_reset();
      q_prev = 1'b0;
      #1;
      chk("por_Q", Q, 1'b0);
      chk("por_BUSY", BUSY, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      RST    = 1'b1;
      edge_n = 0;
      steps(1'b0, 4);

      // 1. reset with D_IN high
      async_reset("rst");

      // 2. clean rise
      D_IN = 1'b0;
      steps(1'b0, 4);
      edge_n = 0; rise_cnt = 0; glitch_cnt = 0; rise_edge = 0;
      steps(1'b1, 22);
      chk("rise_latency", rise_edge, SYNC + DEB);
      chk("rise_count", rise_cnt, 1);
      chk("rise_glitches", glitch_cnt, 0);

      // 4. clean fall, then a rejected 15-cycle low pulse
      edge_n = 0;
      steps(1'b0, 18);
      chk("fall_Q_at_18", Q, 1'b0);
      steps(1'b0, 4);
      steps(1'b1, 22);
      g0 = glitch_cnt;
      steps(1'b0, 15);
      steps(1'b1, 20);
      chk("pulse15_glitch", glitch_cnt - g0, 1);
      chk("pulse15_Q", Q, 1'b1);

      // 3. bounce from Q=0
      steps(1'b0, 22);
      g0 = glitch_cnt; r0 = rise_cnt;
      steps(1'b1, 5);
      steps(1'b0, 3);
      steps(1'b1, 4);
      steps(1'b0, 20);
      chk("bounce_glitches", glitch_cnt - g0, 2);
      chk("bounce_rises", rise_cnt - r0, 0);
      chk("bounce_Q", Q, 1'b0);
      chk("bounce_BUSY", BUSY, 1'b0);

      // 5. EN drop at cnt=8, then restart
      g0 = glitch_cnt;
      k  = 0;
      while (run_m != 8 && k < 40) begin
         step(1'b1, 1'b1);
         k++;
      end
      chk("en_reach_cnt8", run_m, 8);
      step(1'b1, 1'b0);
      chk("en_drop_BUSY", BUSY, 1'b0);
      chk("en_drop_Q", Q, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("en_drop_glitch", glitch_cnt - g0, 0);
      edge_n = 0; rise_edge = 0;
      steps(1'b1, 20);
      chk("en_restart_latency", rise_edge, DEB);

      // 6. reset mid-wait at cnt=10
      steps(1'b0, 22);
      k = 0;
      while (run_m != 10 && k < 40) begin
         step(1'b1, 1'b1);
         k++;
      end
      chk("rst_reach_cnt10", run_m, 10);
      g0 = glitch_cnt;
      async_reset("rst_wait");
      rise_edge = 0;
      steps(1'b1, 22);
      chk("rst_release_latency", rise_edge, SYNC + DEB);
      chk("rst_wait_glitch", glitch_cnt - g0, 0);

      // randomized run lengths, occasional EN drops
      lvl = 1'b0;
      for (int r = 0; r < 250; r++) begin
         len  = $urandom_range(1, 24);
         lvl  = ~lvl;
         for (int i = 0; i < len; i++) begin
            en_r = ($urandom_range(0, 19) != 0);
            step(lvl, en_r);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got %0d expected %0d", 0, 1);
      $fatal(1, "simulation time limit");
   end

endmodule : tb_debounce_sync

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (button, switch, external strobe) into a clean, clock-synchronous level.
- Sits directly upstream of the rising-edge detector. Its Q output feeds the detector's D input, so the detector only ever sees one transition per real input change.
- Internally: a synchronizer chain, then a counter-based debounce FSM with busy and glitch status outputs.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a new level; must be >= 2 (elaboration-time check)
INIT_LEVEL, 0, reset value of the synchronizer flops and of Q; 0 or 1
CNT_W, local, $clog2(DEBOUNCE_CYCLES); not overridable

Ports:
CLK     input   1  system clock, rising edge
RST     input   1  reset, active-low, asynchronous assert, synchronous deassert handled externally
D_IN    input   1  raw asynchronous input
EN      input   1  debounce enable
Q       output  1  debounced level (registered); feeds the edge detector D
BUSY    output  1  high while a candidate transition is being qualified
GLITCH  output  1  one-cycle pulse when a candidate transition is rejected

Behaviour:
Interface and reset:
- One clock (CLK). Reset RST is asynchronous and active-low.
- While RST=0: all synchronizer flops = INIT_LEVEL, Q = INIT_LEVEL, state = STABLE_HI if INIT_LEVEL=1 else STABLE_LO, cnt = 0, BUSY = 0, GLITCH = 0.

Synchronizer:
- SYNC_STAGES-flop shift chain. Call the last stage s.
- A D_IN change meeting setup before edge k appears on s after edge k+SYNC_STAGES-1.

FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. All outputs are registered.
- STABLE_LO: if EN & s=1 -> WAIT_HI, cnt=1. Otherwise stay, cnt=0.
- WAIT_HI:
  - s=0 -> STABLE_LO, cnt=0, GLITCH=1 for one cycle.
  - else cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, Q=1, cnt=0.
  - else cnt++.
- STABLE_HI / WAIT_LO: mirror of the above with polarities swapped. Q=0 on acceptance.

Outputs:
- BUSY = 1 exactly while the state is WAIT_HI or WAIT_LO. It is registered together with the state.
- Q changes only on an acceptance transition and holds otherwise. Any input pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches Q.

Latency:
- D_IN step before edge 1 -> Q changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 18).

EN rules:
- EN=0 in a WAIT state -> return to the matching STABLE state, cnt=0, Q unchanged, GLITCH not asserted.
- EN=0 in a STABLE state -> hold.
- The synchronizer always runs, regardless of EN.

Boundary conditions:
- s returns to the stable level on the same edge that cnt hits DEBOUNCE_CYCLES-1: the reject wins (GLITCH, no Q change), because the terminal sample itself must be at the new level.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset asserted mid-qualification: immediate async return to the reset state. Any pending transition is discarded and no GLITCH is issued.
- GLITCH and an acceptance can never occur on the same cycle.

Decomposition:
- Shared package (project common constants header): the 2-bit FSM state encodings ST_STABLE_LO=0, ST_WAIT_HI=1, ST_STABLE_HI=2, ST_WAIT_LO=3.
- One sub-module: sync_chain (parameters SYNC_STAGES, INIT_LEVEL; ports CLK, RST, D, Q), the plain flop shift chain. It is reusable by other async-input blocks.
- The FSM and counter stay in debounce_sync.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=16, INIT_LEVEL=0, EN=1):
1. Reset: D_IN=1, drop RST mid-cycle -> Q=0, BUSY=0, GLITCH=0 immediately (asynchronously); hold 5 cycles and verify nothing changes until RST=1.
2. Clean rise: D_IN 0->1 before edge 1 and held -> BUSY=1 after edge 3, Q=1 and BUSY=0 after edge 18, GLITCH never pulses; the downstream edge detector sees exactly one rise.
3. Bounce: D_IN high 5 cycles, low 3, high 4, low -> two GLITCH pulses, each one cycle wide, Q stays 0, BUSY=0 at the end.
4. Clean fall from Q=1: D_IN 1->0 held -> Q=0 after 18 edges; a 15-cycle low pulse instead gives GLITCH=1 and Q stays 1.
5. EN drop: start a rise, deassert EN at cnt=8 -> BUSY=0 next edge, no GLITCH, Q=0; reassert EN with D_IN still 1 -> a full 16-cycle qualification restarts.
6. Reset mid-wait: assert RST at cnt=10 during a rise -> Q=0, BUSY=0 at once; after release with D_IN=1 -> Q=1 exactly 18 edges after release.
